hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 16-bit five-stage core. Sits beside the decode/ALU stages.
- Detects load-use hazards and stalls fetch/decode. Flushes wrong-path instructions after a taken jump.
- Produces registered forwarding selects that steer ALU operands to EX/MEM or MEM/WB data.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- REG_W, 3, register-address width (R0..R7)
- FLUSH_CYCLES, 2, cycles of IF/ID + ID/EX squash after a taken jump (1..7)
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..7)
- CNT_W, 16, width of event counters

Ports:
- clk  in  1  core clock, rising-edge state updates
- rst  in  1  asynchronous active-high reset
- id_src1  in  REG_W  first source register of instruction in ID
- id_src2  in  REG_W  second source register of instruction in ID
- id_use1  in  1  ID instruction reads id_src1
- id_use2  in  1  ID instruction reads id_src2
- ex_dst  in  REG_W  destination register of instruction in EX
- ex_wb  in  1  EX instruction writes back
- ex_mem_read  in  1  EX instruction is a load
- mem_dst  in  REG_W  destination of instruction in MEM
- mem_wb  in  1  MEM instruction writes back
- jump_occured  in  1  taken-jump indication from ALU stage (registered there)
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- fwd_sel1  out  2  EX operand-1 source: 0 regfile, 1 EX/MEM result, 2 MEM/WB data
- fwd_sel2  out  2  same for operand 2
- busy  out  1  FSM not in RUN
- stall_cnt  out  CNT_W  total stall cycles, saturating
- flush_cnt  out  CNT_W  total taken-jump events, saturating

Behaviour:
- Reset (async, rst=1): state RUN, internal counter 0, fwd_sel1/2=0, stall_cnt=flush_cnt=0, busy=0. Combinational outputs evaluate as RUN with no hazard: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Hazard term: hz = ex_mem_read & ex_wb & ((id_use1 & id_src1==ex_dst) | (id_use2 & id_src2==ex_dst)).
- FSM states: RUN, STALL, FLUSH. Control outputs are decoded combinationally from state and current inputs. State and counters update on posedge.
- RUN + jump_occured (jump has priority over hz):
  - Same cycle: ifid_flush=1, idex_bubble=1, pc_write=1 (target loads).
  - flush_cnt++.
  - If FLUSH_CYCLES>1: go FLUSH with cnt=FLUSH_CYCLES-2.
- RUN + hz, no jump:
  - Same cycle: pc_write=0, ifid_write=0, idex_bubble=1.
  - stall_cnt++.
  - If LOAD_STALL_CYCLES>1: go STALL with cnt=LOAD_STALL_CYCLES-2.
- STALL:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt++.
  - cnt==0 -> RUN, else cnt--.
  - jump_occured in STALL is ignored, because EX holds a bubble.
- FLUSH:
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1.
  - cnt==0 -> RUN, else cnt--.
  - A further jump_occured in FLUSH is ignored.
- Forwarding: registered on posedge, aligned to the instruction entering EX.
  - Next fwd_selN:
    - 1 if id_useN & ex_wb & !ex_mem_read & id_srcN==ex_dst
    - else 2 if id_useN & mem_wb & id_srcN==mem_dst
    - else 0
  - The EX match wins over the MEM match.
  - When idex_bubble=1 in the same cycle, next fwd_selN=0.
  - A load in EX never yields sel 1. After the stall it is matched via mem_dst and yields sel 2.
- Counters saturate at all-ones. A stall or flush cycle at saturation leaves the value unchanged.
- busy = (state != RUN).
- rst asserted mid-STALL/FLUSH: immediate return to RUN and all reset values. No pending flush is retained.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding: RUN=0, STALL=1, FLUSH=2
  - forwarding-select constants: FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2
  - REG_W default
- One natural sub-module: sat_counter (CNT_W, inc, clk, rst), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: EX load ex_dst=3, ID id_src1=3 id_use1=1 -> same cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle RUN with mem_dst=3 -> fwd_sel1=2. stall_cnt=1.
- ALU forward: ex_wb=1 ex_dst=5 non-load, id_src2=5 -> after posedge fwd_sel2=1, no stall. ex_dst=5 and mem_dst=5 both match -> fwd_sel2=1.
- Taken jump with FLUSH_CYCLES=2: jump_occured pulse -> ifid_flush=idex_bubble=1 for exactly 2 cycles, busy=1 in the second cycle only, flush_cnt=1.
- Jump and hz in the same cycle -> flush path taken, pc_write=1, stall_cnt unchanged.
- LOAD_STALL_CYCLES=3: one hazard -> pc_write=0 for 3 consecutive cycles, stall_cnt=3, then RUN.
- Reset during FLUSH: assert rst in cycle 2 of a flush -> asynchronously pc_write=1, ifid_flush=0, counters 0, fwd_sel=0. Counter at 0xFFFF plus a stall stays 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control.
package cpu_pkg;

    localparam int unsigned DEF_REG_W = 3;
    localparam int unsigned SEQ_W     = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Operand source pick; a younger EX producer wins over MEM, loads in EX never forward.
    function automatic logic [1:0] fwd_pick(
        input logic use_src,
        input logic ex_wb,
        input logic ex_load,
        input logic ex_hit,
        input logic mem_wb,
        input logic mem_hit
    );
        if (use_src && ex_wb && !ex_load && ex_hit) begin
            return FWD_EXMEM;
        end
        if (use_src && mem_wb && mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side view of the hazard control unit: stage info in, control/forwarding out.
interface hazard_control_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned REG_W = DEF_REG_W,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_use1;
    logic             id_use2;
    logic [REG_W-1:0] ex_dst;
    logic             ex_wb;
    logic             ex_mem_read;
    logic [REG_W-1:0] mem_dst;
    logic             mem_wb;
    logic             jump_occured;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_src1, id_src2, id_use1, id_use2, ex_dst, ex_wb, ex_mem_read,
               mem_dst, mem_wb, jump_occured,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_sel1, fwd_sel2,
               busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_use1, id_use2, ex_dst, ex_wb, ex_mem_read,
               mem_dst, mem_wb, jump_occured,
        output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_sel1, fwd_sel2,
               busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // Count events until the all-ones ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall, taken-jump flush and operand forwarding control for the 5-stage core.
module hazard_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned REG_W             = DEF_REG_W,
    parameter int unsigned FLUSH_CYCLES      = 2,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input logic                  clk,
    input logic                  rst,
    hazard_control_unit_if.slave bus
);
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] ex_dst;
    logic [REG_W-1:0] mem_dst;
    logic             hz;
    state_t           state;
    state_t           next_state;
    logic [SEQ_W-1:0] seq;
    logic [SEQ_W-1:0] next_seq;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             stall_ev;
    logic             flush_ev;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic [1:0]       next_sel1;
    logic [1:0]       next_sel2;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign src1    = bus.id_src1;
    assign src2    = bus.id_src2;
    assign ex_dst  = bus.ex_dst;
    assign mem_dst = bus.mem_dst;

    // Load in EX feeding an operand the ID instruction actually reads.
    assign hz = bus.ex_mem_read && bus.ex_wb &&
                ((bus.id_use1 && (src1 == ex_dst)) || (bus.id_use2 && (src2 == ex_dst)));

    // State and remaining-cycle register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            seq   <= '0;
        end else begin
            state <= next_state;
            seq   <= next_seq;
        end
    end

    // Next state and pipeline control; jump outranks a load-use hazard.
    always_comb begin
        next_state  = state;
        next_seq    = seq;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.jump_occured) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_ev    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        next_state = FLUSH;
                        next_seq   = SEQ_W'(FLUSH_CYCLES - 2);
                    end
                end else if (hz) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_ev    = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        next_state = STALL;
                        next_seq   = SEQ_W'(LOAD_STALL_CYCLES - 2);
                    end
                end
            end
            STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                stall_ev    = 1'b1;
                if (seq == '0) begin
                    next_state = RUN;
                end else begin
                    next_seq = seq - SEQ_W'(1);
                end
            end
            FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (seq == '0) begin
                    next_state = RUN;
                end else begin
                    next_seq = seq - SEQ_W'(1);
                end
            end
            default: begin
                next_state = RUN;
                next_seq   = '0;
            end
        endcase
    end

    // Operand selects for the instruction about to enter EX; a bubble gets none.
    always_comb begin
        next_sel1 = fwd_pick(bus.id_use1, bus.ex_wb, bus.ex_mem_read, src1 == ex_dst,
                             bus.mem_wb, src1 == mem_dst);
        next_sel2 = fwd_pick(bus.id_use2, bus.ex_wb, bus.ex_mem_read, src2 == ex_dst,
                             bus.mem_wb, src2 == mem_dst);
        if (idex_bubble) begin
            next_sel1 = FWD_RF;
            next_sel2 = FWD_RF;
        end
    end

    // Forwarding select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel1 <= FWD_RF;
            fwd_sel2 <= FWD_RF;
        end else begin
            fwd_sel1 <= next_sel1;
            fwd_sel2 <= next_sel2;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_ev),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_ev),
        .count (flush_cnt)
    );

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.fwd_sel1    = fwd_sel1;
    assign bus.fwd_sel2    = fwd_sel2;
    assign bus.busy        = (state != RUN);
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: default config (A) and FLUSH=3/STALL=3/4-bit counters (B).
module tb_hazard_control_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_control_unit_if #(.REG_W(3), .CNT_W(16)) ifa ();
    hazard_control_unit_if #(.REG_W(3), .CNT_W(4))  ifb ();

    assign ifb.id_src1      = ifa.id_src1;
    assign ifb.id_src2      = ifa.id_src2;
    assign ifb.id_use1      = ifa.id_use1;
    assign ifb.id_use2      = ifa.id_use2;
    assign ifb.ex_dst       = ifa.ex_dst;
    assign ifb.ex_wb        = ifa.ex_wb;
    assign ifb.ex_mem_read  = ifa.ex_mem_read;
    assign ifb.mem_dst      = ifa.mem_dst;
    assign ifb.mem_wb       = ifa.mem_wb;
    assign ifb.jump_occured = ifa.jump_occured;

    hazard_control_unit #(.REG_W(3), .FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    hazard_control_unit #(.REG_W(3), .FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Reference model: cycles of squash/stall still owed, event totals, expected selects.
    int flush_left [2];
    int stall_left [2];
    int m_sc [2];
    int m_fc [2];
    int m_s1 [2];
    int m_s2 [2];

    // Observed / expected snapshot of the last cycle.
    logic [3:0] o_ctl [2];
    logic [3:0] e_ctl [2];
    logic [1:0] o_s1 [2];
    logic [1:0] o_s2 [2];
    logic       o_busy [2];
    logic       e_busy [2];
    int         o_sc [2];
    int         o_fc [2];

    function automatic int fc(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int lsc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int maxc(input int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    function automatic bit load_use();
        return ifa.ex_mem_read && ifa.ex_wb &&
               ((ifa.id_use1 && ifa.id_src1 == ifa.ex_dst) ||
                (ifa.id_use2 && ifa.id_src2 == ifa.ex_dst));
    endfunction

    function automatic int exp_fwd(input logic u, input logic [2:0] s);
        if (u && ifa.ex_wb && !ifa.ex_mem_read && s == ifa.ex_dst) return 1;
        if (u && ifa.mem_wb && s == ifa.mem_dst) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            flush_left[i] = 0;
            stall_left[i] = 0;
            m_sc[i] = 0;
            m_fc[i] = 0;
            m_s1[i] = 0;
            m_s2[i] = 0;
        end
    endtask

    task automatic capture(input bit regs_only);
        if (!regs_only) begin
            o_ctl[0] = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_bubble};
            o_ctl[1] = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_bubble};
        end
        o_s1[0] = ifa.fwd_sel1;  o_s2[0] = ifa.fwd_sel2;
        o_s1[1] = ifb.fwd_sel1;  o_s2[1] = ifb.fwd_sel2;
        o_busy[0] = ifa.busy;    o_busy[1] = ifb.busy;
        o_sc[0] = int'(ifa.stall_cnt);  o_fc[0] = int'(ifa.flush_cnt);
        o_sc[1] = int'(ifb.stall_cnt);  o_fc[1] = int'(ifb.flush_cnt);
    endtask

    // One clock with inputs as currently driven; leaves time at the next negedge.
    task automatic run_cycle();
        int kind [2];
        int s1;
        int s2;
        #1;
        s1 = exp_fwd(ifa.id_use1, ifa.id_src1);
        s2 = exp_fwd(ifa.id_use2, ifa.id_src2);
        for (int i = 0; i < 2; i++) begin
            if (flush_left[i] > 0)      kind[i] = 2;
            else if (stall_left[i] > 0) kind[i] = 1;
            else if (ifa.jump_occured)  kind[i] = 2;
            else if (load_use())        kind[i] = 1;
            else                        kind[i] = 0;
            e_ctl[i] = (kind[i] == 2) ? 4'b1111 : (kind[i] == 1) ? 4'b0001 : 4'b1100;
        end
        capture(1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (kind[i] == 2) begin
                if (flush_left[i] > 0) flush_left[i]--;
                else begin
                    flush_left[i] = fc(i) - 1;
                    if (m_fc[i] < maxc(i)) m_fc[i]++;
                end
            end else if (kind[i] == 1) begin
                if (stall_left[i] > 0) stall_left[i]--;
                else stall_left[i] = lsc(i) - 1;
                if (m_sc[i] < maxc(i)) m_sc[i]++;
            end
            m_s1[i] = (kind[i] == 0) ? s1 : 0;
            m_s2[i] = (kind[i] == 0) ? s2 : 0;
            e_busy[i] = (flush_left[i] > 0) || (stall_left[i] > 0);
        end
        capture(1'b1);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [2:0] s1, input logic u1, input logic [2:0] s2, input logic u2,
                          input logic [2:0] exd, input logic exwb, input logic exld,
                          input logic [2:0] memd, input logic memwb, input logic jmp);
        ifa.id_src1 = s1;  ifa.id_use1 = u1;
        ifa.id_src2 = s2;  ifa.id_use2 = u2;
        ifa.ex_dst = exd;  ifa.ex_wb = exwb;  ifa.ex_mem_read = exld;
        ifa.mem_dst = memd; ifa.mem_wb = memwb;
        ifa.jump_occured = jmp;
    endtask

    task automatic set_neutral();
        set_in(3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_neutral();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        capture(1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_ctl[i] !== 4'b1100) begin
                errors++;
                $display("FAIL reset_ctl dut%0d got %b exp 1100", i, o_ctl[i]);
            end
            checks++;
            if (o_s1[i] !== 2'd0 || o_s2[i] !== 2'd0 || o_busy[i] !== 1'b0 ||
                o_sc[i] != 0 || o_fc[i] != 0) begin
                errors++;
                $display("FAIL reset_regs dut%0d got s1=%0d s2=%0d busy=%b sc=%0d fc=%0d exp all 0",
                         i, o_s1[i], o_s2[i], o_busy[i], o_sc[i], o_fc[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(3'd3, 1'b1, 3'd6, 1'b0, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        run_cycle();
        checks++;
        if (o_ctl[0] !== 4'b0001 || o_ctl[0] !== e_ctl[0]) begin
            errors++;
            $display("FAIL load_use_stall got %b exp 0001 (model %b)", o_ctl[0], e_ctl[0]);
        end
        // Load has moved to MEM; ID still waits on R3.
        set_in(3'd3, 1'b1, 3'd6, 1'b0, 3'd2, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        run_cycle();
        checks++;
        if (o_ctl[0] !== 4'b1100) begin
            errors++;
            $display("FAIL load_use_resume got %b exp 1100", o_ctl[0]);
        end
        checks++;
        if (o_s1[0] !== FWD_MEMWB || o_s1[0] !== 2'(m_s1[0])) begin
            errors++;
            $display("FAIL load_use_fwd got %0d exp 2", o_s1[0]);
        end
        checks++;
        if (o_sc[0] != 1 || o_sc[0] != m_sc[0]) begin
            errors++;
            $display("FAIL load_use_cnt got %0d exp 1", o_sc[0]);
        end
        set_neutral();
    endtask

    task automatic test_alu_forward();
        do_reset();
        set_in(3'd1, 1'b0, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
        run_cycle();
        checks++;
        if (o_s2[0] !== 2'd1 || o_ctl[0] !== 4'b1100 || o_s1[0] !== 2'd0) begin
            errors++;
            $display("FAIL alu_fwd got sel2=%0d sel1=%0d ctl=%b exp 1 0 1100", o_s2[0], o_s1[0], o_ctl[0]);
        end
        set_in(3'd5, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
        run_cycle();
        checks++;
        if (o_s2[0] !== 2'd1 || o_s1[0] !== 2'd1 || o_s2[1] !== 2'(m_s2[1])) begin
            errors++;
            $display("FAIL alu_fwd_prio got a.sel1=%0d a.sel2=%0d b.sel2=%0d exp 1 1 %0d",
                     o_s1[0], o_s2[0], o_s2[1], m_s2[1]);
        end
        set_neutral();
    endtask

    task automatic test_jump();
        do_reset();
        set_neutral();
        ifa.jump_occured = 1'b1;
        run_cycle();
        checks++;
        if (o_ctl[0] !== 4'b1111 || o_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL jump_c1 got ctl=%b busy=%b exp 1111 1", o_ctl[0], o_busy[0]);
        end
        ifa.jump_occured = 1'b0;
        run_cycle();
        checks++;
        if (o_ctl[0] !== 4'b1111 || o_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL jump_c2 got ctl=%b busy_after=%b exp 1111 0", o_ctl[0], o_busy[0]);
        end
        run_cycle();
        checks++;
        if (o_ctl[0] !== 4'b1100 || o_fc[0] != 1 || o_ctl[1] !== e_ctl[1]) begin
            errors++;
            $display("FAIL jump_end got ctl=%b fc=%0d b.ctl=%b exp 1100 1 %b",
                     o_ctl[0], o_fc[0], o_ctl[1], e_ctl[1]);
        end
        run_cycle();
        checks++;
        if (o_ctl[1] !== 4'b1100 || o_fc[1] != 1) begin
            errors++;
            $display("FAIL jump_end_b got ctl=%b fc=%0d exp 1100 1", o_ctl[1], o_fc[1]);
        end
    endtask

    task automatic test_jump_hz();
        int sc_before;
        do_reset();
        sc_before = m_sc[0];
        set_in(3'd4, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
        run_cycle();
        checks++;
        if (o_ctl[0] !== 4'b1111 || o_sc[0] != sc_before || o_fc[0] != 1) begin
            errors++;
            $display("FAIL jump_hz got ctl=%b sc=%0d fc=%0d exp 1111 %0d 1", o_ctl[0], o_sc[0], o_fc[0], sc_before);
        end
        set_neutral();
        repeat (3) run_cycle();
    endtask

    task automatic test_long_stall();
        do_reset();
        set_in(3'd0, 1'b0, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            if (c == 0) set_neutral();
            checks++;
            if (o_ctl[1][3] !== ((c == 3) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL long_stall_c%0d got pc_write=%b exp %b", c, o_ctl[1][3], (c == 3));
            end
        end
        checks++;
        if (o_sc[1] != 3 || o_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL long_stall_cnt got sc=%0d busy=%b exp 3 0", o_sc[1], o_busy[1]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int h = 0; h < 6; h++) begin
            set_in(3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
            run_cycle();
            set_neutral();
            run_cycle();
            run_cycle();
            if (h >= 4) begin
                checks++;
                if (o_sc[1] != 15 || o_sc[1] != m_sc[1] || o_sc[0] != m_sc[0]) begin
                    errors++;
                    $display("FAIL saturate_h%0d got b.sc=%0d a.sc=%0d exp 15 %0d", h, o_sc[1], o_sc[0], m_sc[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                   3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                   3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 9) == 0));
            run_cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_ctl[i] !== e_ctl[i]) begin
                    errors++;
                    $display("FAIL rnd_ctl n=%0d dut%0d got %b exp %b", n, i, o_ctl[i], e_ctl[i]);
                end
                checks++;
                if (o_s1[i] !== 2'(m_s1[i]) || o_s2[i] !== 2'(m_s2[i])) begin
                    errors++;
                    $display("FAIL rnd_fwd n=%0d dut%0d got %0d/%0d exp %0d/%0d",
                             n, i, o_s1[i], o_s2[i], m_s1[i], m_s2[i]);
                end
                checks++;
                if (o_busy[i] !== e_busy[i] || o_sc[i] != m_sc[i] || o_fc[i] != m_fc[i]) begin
                    errors++;
                    $display("FAIL rnd_regs n=%0d dut%0d got busy=%b sc=%0d fc=%0d exp %b %0d %0d",
                             n, i, o_busy[i], o_sc[i], o_fc[i], e_busy[i], m_sc[i], m_fc[i]);
                end
            end
        end
        set_neutral();
    endtask

    task automatic test_reset_in_flush();
        set_neutral();
        ifa.jump_occured = 1'b1;
        run_cycle();
        ifa.jump_occured = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        capture(1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_ctl[i] !== 4'b1100 || o_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL rst_flush_ctl dut%0d got ctl=%b busy=%b exp 1100 0", i, o_ctl[i], o_busy[i]);
            end
            checks++;
            if (o_sc[i] != 0 || o_fc[i] != 0 || o_s1[i] !== 2'd0 || o_s2[i] !== 2'd0) begin
                errors++;
                $display("FAIL rst_flush_regs dut%0d got sc=%0d fc=%0d s1=%0d s2=%0d exp 0",
                         i, o_sc[i], o_fc[i], o_s1[i], o_s2[i]);
            end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run_cycle();
        checks++;
        if (o_ctl[0] !== 4'b1100 || o_ctl[1] !== 4'b1100) begin
            errors++;
            $display("FAIL rst_flush_after got %b %b exp 1100 1100", o_ctl[0], o_ctl[1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_neutral();
        model_reset();
        test_reset();
        test_load_use();
        test_alu_forward();
        test_jump();
        test_jump_hz();
        test_long_stall();
        test_saturation();
        do_reset();
        test_random();
        test_reset_in_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a wait ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1);
    end
endmodule
